operand_fetch: RTL

Decode/operand-fetch stage between instruction fetch and execute. Accepts 32-bit Tinker instructions over a valid/ready handshake and drives the register file's two read addresses. Latches the decoded fields and both 64-bit operands into an output pipeline register. A 32-entry pending-write scoreboard, cleared by the writeback port, stalls RAW/WAW hazards.

---
 rtl/tinker_pkg.sv | 46 ++++
 rtl/scoreboard.sv | 49 ++++
 rtl/operand_fetch.sv | 114 +++++++++++
 3 files changed

// File: rtl/tinker_pkg.sv
// Shared Tinker ISA definitions: field positions, opcodes, the writes_rd decode
// and the operand-fetch output bundle.
package tinker_pkg;

    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned XLEN     = 64;
    localparam int unsigned INSTR_W  = 32;
    localparam int unsigned REG_AW   = 5;
    localparam int unsigned OPC_W    = 5;
    localparam int unsigned IMM_W    = 12;

    localparam int unsigned OPC_LSB  = 27;
    localparam int unsigned RD_LSB   = 22;
    localparam int unsigned RS_LSB   = 17;
    localparam int unsigned RT_LSB   = 12;
    localparam int unsigned IMM_LSB  = 0;

    localparam logic [OPC_W-1:0] OP_BR     = 5'h08;
    localparam logic [OPC_W-1:0] OP_BRR_R  = 5'h09;
    localparam logic [OPC_W-1:0] OP_BRR_L  = 5'h0A;
    localparam logic [OPC_W-1:0] OP_BRNZ   = 5'h0B;
    localparam logic [OPC_W-1:0] OP_CALL   = 5'h0C;
    localparam logic [OPC_W-1:0] OP_RETURN = 5'h0D;
    localparam logic [OPC_W-1:0] OP_BRGT   = 5'h0E;
    localparam logic [OPC_W-1:0] OP_PRIV   = 5'h0F;
    localparam logic [OPC_W-1:0] OP_MOV_ST = 5'h13;
    localparam logic [OPC_W-1:0] OP_ADD    = 5'h18;
    localparam logic [OPC_W-1:0] OP_ADDI   = 5'h19;
    localparam logic [OPC_W-1:0] OP_SUB    = 5'h1A;

    // Control-flow ops and the store form of mov leave rd untouched.
    function automatic logic writes_rd(input logic [OPC_W-1:0] opc);
        return !(((opc >= OP_BR) && (opc <= OP_PRIV)) || (opc == OP_MOV_ST));
    endfunction

    typedef struct packed {
        logic [OPC_W-1:0]  opcode;
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   rs_val;
        logic [XLEN-1:0]   rt_val;
        logic [IMM_W-1:0]  imm;
        logic [XLEN-1:0]   pc;
        logic              writes_rd;
    } of_bundle_t;

endpackage

// File: rtl/scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue, cleared on writeback.
// OPERAND_FETCH_BYPASS_EN lets a same-cycle writeback mask the hazard query.
module scoreboard
    import tinker_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              i_set_en,
    input  logic [REG_AW-1:0] i_set_idx,
    input  logic              i_clr_en,
    input  logic [REG_AW-1:0] i_clr_idx,
    input  logic [REG_AW-1:0] i_q_rs,
    input  logic [REG_AW-1:0] i_q_rt,
    input  logic [REG_AW-1:0] i_q_rd,
    input  logic              i_q_rd_en,
    output logic              o_hazard_c
);

    logic [NUM_REGS-1:0] r_pending;
    logic [NUM_REGS-1:0] w_set_mask;
    logic [NUM_REGS-1:0] w_clr_mask;
    logic [NUM_REGS-1:0] w_eff_pending;

    assign w_set_mask = i_set_en ? (NUM_REGS'(1) << i_clr_idx_sel(i_set_idx)) : '0;
    assign w_clr_mask = i_clr_en ? (NUM_REGS'(1) << i_clr_idx_sel(i_clr_idx)) : '0;

    function automatic logic [REG_AW-1:0] i_clr_idx_sel(input logic [REG_AW-1:0] idx);
        return idx;
    endfunction

`ifdef OPERAND_FETCH_BYPASS_EN
    assign w_eff_pending = r_pending & ~w_clr_mask;
`else
    assign w_eff_pending = r_pending;
`endif

    assign o_hazard_c = w_eff_pending[i_q_rs] | w_eff_pending[i_q_rt] |
                        (i_q_rd_en & w_eff_pending[i_q_rd]);

    // Set is applied after clear so an issue to the retiring register stays pending.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clr_mask) | w_set_mask;
        end
    end

endmodule

// File: rtl/operand_fetch.sv
// Decode/operand-fetch stage: reads rs/rt, stalls on scoreboard hazards, registers the bundle.
// OPERAND_FETCH_BYPASS_EN forwards wb_data into operands and releases same-cycle hazards.
module operand_fetch
    import tinker_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [XLEN-1:0]    in_pc,
    output logic [REG_AW-1:0]  rf_rs_addr,
    output logic [REG_AW-1:0]  rf_rt_addr,
    input  logic [XLEN-1:0]    rf_rs_data,
    input  logic [XLEN-1:0]    rf_rt_data,
    input  logic               wb_valid,
    input  logic [REG_AW-1:0]  wb_rd,
    input  logic [XLEN-1:0]    wb_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OPC_W-1:0]   out_opcode,
    output logic [REG_AW-1:0]  out_rd,
    output logic [XLEN-1:0]    out_rs_val,
    output logic [XLEN-1:0]    out_rt_val,
    output logic [IMM_W-1:0]   out_imm,
    output logic [XLEN-1:0]    out_pc,
    output logic               out_writes_rd,
    output logic               hazard_stall
);

    logic [OPC_W-1:0]  w_opcode;
    logic [REG_AW-1:0] w_rd;
    logic [REG_AW-1:0] w_rs;
    logic [REG_AW-1:0] w_rt;
    logic [IMM_W-1:0]  w_imm;
    logic              w_writes_rd;
    logic              w_sb_hazard;
    logic              w_hazard;
    logic              w_accept;
    logic [XLEN-1:0]   w_rs_val;
    logic [XLEN-1:0]   w_rt_val;

    of_bundle_t r_out;
    logic       r_valid;

    assign w_opcode    = in_instr[OPC_LSB +: OPC_W];
    assign w_rd        = in_instr[RD_LSB  +: REG_AW];
    assign w_rs        = in_instr[RS_LSB  +: REG_AW];
    assign w_rt        = in_instr[RT_LSB  +: REG_AW];
    assign w_imm       = in_instr[IMM_LSB +: IMM_W];
    assign w_writes_rd = writes_rd(w_opcode);

    assign rf_rs_addr = w_rs;
    assign rf_rt_addr = w_rt;

    // Backpressure alone never raises hazard_stall; only the scoreboard does.
    assign w_hazard     = in_valid && w_sb_hazard;
    assign hazard_stall = w_hazard;
    assign in_ready     = !w_hazard && (!r_valid || out_ready);
    assign w_accept     = in_valid && in_ready;

`ifdef OPERAND_FETCH_BYPASS_EN
    assign w_rs_val = (wb_valid && (wb_rd == w_rs)) ? wb_data : rf_rs_data;
    assign w_rt_val = (wb_valid && (wb_rd == w_rt)) ? wb_data : rf_rt_data;
`else
    logic w_unused_wb;
    assign w_unused_wb = ^wb_data;
    assign w_rs_val    = rf_rs_data;
    assign w_rt_val    = rf_rt_data;
`endif

    scoreboard u_scoreboard (
        .clk        (clk),
        .reset      (reset),
        .i_set_en   (w_accept && w_writes_rd),
        .i_set_idx  (w_rd),
        .i_clr_en   (wb_valid),
        .i_clr_idx  (wb_rd),
        .i_q_rs     (w_rs),
        .i_q_rt     (w_rt),
        .i_q_rd     (w_rd),
        .i_q_rd_en  (w_writes_rd),
        .o_hazard_c (w_sb_hazard)
    );

    // Output pipeline register: load on accept, drop on release, otherwise hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_out   <= '0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_out   <= '{opcode:    w_opcode,
                         rd:        w_rd,
                         rs_val:    w_rs_val,
                         rt_val:    w_rt_val,
                         imm:       w_imm,
                         pc:        in_pc,
                         writes_rd: w_writes_rd};
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid     = r_valid;
    assign out_opcode    = r_out.opcode;
    assign out_rd        = r_out.rd;
    assign out_rs_val    = r_out.rs_val;
    assign out_rt_val    = r_out.rt_val;
    assign out_imm       = r_out.imm;
    assign out_pc        = r_out.pc;
    assign out_writes_rd = r_out.writes_rd;

endmodule
